// File: rtl/spi_frame_ctrl_if.sv
// Word-level link between the frame controller and the SPI shifter.
interface spi_frame_ctrl_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       word_done_i;
    logic       cs_n_o;

    modport master (
        output tx_data_o,
        output tx_valid_o,
        output cs_n_o,
        input  tx_ready_i,
        input  word_done_i
    );

    modport slave (
        input  tx_data_o,
        input  tx_valid_o,
        input  cs_n_o,
        output tx_ready_i,
        output word_done_i
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Sends a 3-word frame (HEADER, snapshot of the payload counter, XOR checksum)
// to an SPI shifter, framing it with chip-select setup and hold time.
module spi_frame_ctrl #(
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic             clk_100,
    input  logic             s_rst,
    input  logic             next_count_i,
    input  logic             start_send_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             dropped_o,
    output logic [7:0]       count_o,
    spi_frame_ctrl_if.master spi
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [1:0] WORDS_LAST = 2'd3;

    state_t     state_r;
    logic [7:0] count_r;
    logic [7:0] snap_r;
    logic [7:0] phase_cnt_r;
    logic [1:0] word_idx_r;
    logic [7:0] tx_data_r;
    logic       tx_valid_r;
    logic       cs_n_r;
    logic       busy_r;
    logic       frame_done_r;
    logic       dropped_r;

    // Index 0 is the header, 1 the payload, 2 the checksum.
    function automatic logic [7:0] frame_word(input logic [1:0] idx, input logic [7:0] snap);
        logic [7:0] word;
        case (idx)
            2'd0:    word = HEADER;
            2'd1:    word = snap;
            2'd2:    word = HEADER ^ snap;
            default: word = HEADER;
        endcase
        return word;
    endfunction

    // Frame sequencer, payload counter and every registered output.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_r      <= ST_IDLE;
            count_r      <= 8'h00;
            snap_r       <= 8'h00;
            phase_cnt_r  <= 8'h00;
            word_idx_r   <= 2'd0;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            cs_n_r       <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            dropped_r    <= 1'b0;
        end else begin
            count_r      <= count_r + {7'd0, next_count_i};
            frame_done_r <= 1'b0;
            dropped_r    <= start_send_i & busy_r;
            case (state_r)
                ST_IDLE: begin
                    if (start_send_i) begin
                        // Snapshot uses the pre-increment counter value.
                        state_r     <= ST_SETUP;
                        snap_r      <= count_r;
                        cs_n_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        phase_cnt_r <= 8'h00;
                        word_idx_r  <= 2'd0;
                    end
                end
                ST_SETUP: begin
                    if (phase_cnt_r == SETUP_LAST) begin
                        state_r    <= ST_SEND;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= frame_word(2'd0, snap_r);
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 8'd1;
                    end
                end
                ST_SEND: begin
                    if (spi.tx_ready_i) begin
                        state_r    <= ST_WAIT;
                        tx_valid_r <= 1'b0;
                        word_idx_r <= word_idx_r + 2'd1;
                    end
                end
                ST_WAIT: begin
                    if (spi.word_done_i) begin
                        if (word_idx_r == WORDS_LAST) begin
                            state_r     <= ST_HOLD;
                            phase_cnt_r <= 8'h00;
                        end else begin
                            state_r    <= ST_SEND;
                            tx_valid_r <= 1'b1;
                            tx_data_r  <= frame_word(word_idx_r, snap_r);
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_cnt_r == HOLD_LAST) begin
                        state_r      <= ST_IDLE;
                        cs_n_r       <= 1'b1;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                    cs_n_r     <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign spi.tx_data_o  = tx_data_r;
    assign spi.tx_valid_o = tx_valid_r;
    assign spi.cs_n_o     = cs_n_r;
    assign busy_o         = busy_r;
    assign frame_done_o   = frame_done_r;
    assign dropped_o      = dropped_r;
    assign count_o        = count_r;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: cycle-by-cycle vector table plus multi-cycle frame sequences.
module tb_spi_frame_ctrl;

    logic       clk_100 = 1'b0;
    logic       s_rst = 1'b1;
    logic       next_count = 1'b0;
    logic       start_send = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       dropped;
    logic [7:0] count;
    int         n_checks = 0;
    int         n_errors = 0;

    spi_frame_ctrl_if bus();

    spi_frame_ctrl dut (
        .clk_100      (clk_100),
        .s_rst        (s_rst),
        .next_count_i (next_count),
        .start_send_i (start_send),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .dropped_o    (dropped),
        .count_o      (count),
        .spi          (bus)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic       nc, ss, rdy, wd;
        logic       valid;
        logic [7:0] data;
        logic       csn, busy, fd, drop;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic nc, ss, rdy, wd, valid, input logic [7:0] data,
                           input logic csn, bsy, fd, drop, input logic [7:0] cnt);
        vec_t v;
        v.nc = nc; v.ss = ss; v.rdy = rdy; v.wd = wd; v.valid = valid; v.data = data;
        v.csn = csn; v.busy = bsy; v.fd = fd; v.drop = drop; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk_100);
        s_rst = 1'b1; next_count = 1'b0; start_send = 1'b0;
        bus.tx_ready_i = 1'b0; bus.word_done_i = 1'b0;
        @(negedge clk_100);
        s_rst = 1'b0;
    endtask

    task automatic pulse_count(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100); next_count = 1'b1;
            @(negedge clk_100); next_count = 1'b0;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.tx_valid_o) ok = 1'b1;
            else @(negedge clk_100);
        end
    endtask

    // Runs one frame with a well-behaved shifter; the first word is stalled rdy_delay cycles.
    task automatic run_frame(input int rdy_delay, output logic [23:0] words, output int nwords,
                             output int pre_low, output int nfd, output int n_stall, output int stall_bad);
        int wd_cnt;
        bit seen_valid;
        words = 24'h0; nwords = 0; pre_low = 0; nfd = 0; n_stall = 0; stall_bad = 0;
        wd_cnt = -1; seen_valid = 1'b0;
        @(negedge clk_100); start_send = 1'b1;
        @(negedge clk_100); start_send = 1'b0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (bus.tx_valid_o) seen_valid = 1'b1;
            if (!seen_valid && !bus.cs_n_o) pre_low++;
            if (frame_done) nfd++;
            bus.tx_ready_i = bus.tx_valid_o && (n_stall >= rdy_delay);
            if (bus.tx_valid_o && !bus.tx_ready_i) begin
                n_stall++;
                if (bus.tx_data_o !== 8'hA5) stall_bad++;
            end
            bus.word_done_i = (wd_cnt == 0);
            if (wd_cnt >= 0) wd_cnt--;
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                if (nwords < 3) words = {words[15:0], bus.tx_data_o};
                nwords++;
                wd_cnt = 7;
            end
            @(negedge clk_100);
        end
        bus.tx_ready_i = 1'b0; bus.word_done_i = 1'b0;
    endtask

    initial begin
        logic [23:0] words;
        int          nwords, pre_low, nfd, n_stall, stall_bad, fd_seen;
        bit          ok, found, wd_pend;

        bus.tx_ready_i = 1'b0;
        bus.word_done_i = 1'b0;

        // Reset values
        @(negedge clk_100);
        @(negedge clk_100);
        check("reset_outputs", {bus.tx_valid_o, bus.tx_data_o, bus.cs_n_o, busy, frame_done, dropped, count},
              {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        s_rst = 1'b0;

        // Vector table: counter at 07, coincident start+increment, drop in WAIT, ignored word_done.
        add_vec(1,1,0,0, 0,8'h00, 0,1,0,0, 8'h08);
        add_vec(0,0,0,0, 0,8'h00, 0,1,0,0, 8'h08);
        add_vec(0,0,0,1, 0,8'h00, 0,1,0,0, 8'h08);
        add_vec(0,0,0,0, 0,8'h00, 0,1,0,0, 8'h08);
        add_vec(0,0,0,0, 1,8'hA5, 0,1,0,0, 8'h08);
        add_vec(0,0,0,1, 1,8'hA5, 0,1,0,0, 8'h08);
        add_vec(0,0,1,0, 0,8'hA5, 0,1,0,0, 8'h08);
        add_vec(0,1,0,0, 0,8'hA5, 0,1,0,1, 8'h08);
        add_vec(1,0,0,0, 0,8'hA5, 0,1,0,0, 8'h09);
        add_vec(0,0,0,1, 1,8'h07, 0,1,0,0, 8'h09);
        add_vec(0,0,1,0, 0,8'h07, 0,1,0,0, 8'h09);
        add_vec(0,0,0,1, 1,8'hA2, 0,1,0,0, 8'h09);
        add_vec(0,0,1,0, 0,8'hA2, 0,1,0,0, 8'h09);
        add_vec(0,0,0,1, 0,8'hA2, 0,1,0,0, 8'h09);
        add_vec(0,0,0,0, 0,8'hA2, 0,1,0,0, 8'h09);
        add_vec(0,0,0,0, 0,8'hA2, 0,1,0,0, 8'h09);
        add_vec(0,0,0,0, 0,8'hA2, 0,1,0,0, 8'h09);
        add_vec(0,0,0,0, 0,8'hA2, 1,0,1,0, 8'h09);
        add_vec(0,0,0,1, 0,8'hA2, 1,0,0,0, 8'h09);

        do_reset();
        pulse_count(7);
        for (int i = 0; i < tbl.size(); i++) begin
            next_count = tbl[i].nc; start_send = tbl[i].ss;
            bus.tx_ready_i = tbl[i].rdy; bus.word_done_i = tbl[i].wd;
            @(negedge clk_100);
            check($sformatf("vec%0d", i),
                  {bus.tx_valid_o, bus.tx_data_o, bus.cs_n_o, busy, frame_done, dropped, count},
                  {tbl[i].valid, tbl[i].data, tbl[i].csn, tbl[i].busy, tbl[i].fd, tbl[i].drop, tbl[i].cnt});
        end
        next_count = 1'b0; start_send = 1'b0; bus.tx_ready_i = 1'b0; bus.word_done_i = 1'b0;

        // start_send in the frame_done cycle is accepted
        @(negedge clk_100); start_send = 1'b1;
        @(negedge clk_100); start_send = 1'b0;
        found = 1'b0; wd_pend = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (frame_done) begin
                found = 1'b1; start_send = 1'b1;
                bus.tx_ready_i = 1'b0; bus.word_done_i = 1'b0;
            end else begin
                bus.word_done_i = wd_pend;
                bus.tx_ready_i = bus.tx_valid_o;
                wd_pend = bus.tx_valid_o;
                @(negedge clk_100);
            end
        end
        check("restart_frame_done_seen", {31'd0, found}, 32'd1);
        @(negedge clk_100); start_send = 1'b0;
        check("restart_accepted", {bus.cs_n_o, busy, dropped, frame_done}, {1'b0, 1'b1, 1'b0, 1'b0});

        // Basic frame after 3 increments
        do_reset();
        pulse_count(3);
        run_frame(0, words, nwords, pre_low, nfd, n_stall, stall_bad);
        check("frame3_words", {8'h00, words}, {8'h00, 24'hA503A6});
        check("frame3_nwords", nwords, 32'd3);
        check("frame3_setup_low", pre_low, 32'd4);
        check("frame3_frame_done", nfd, 32'd1);

        // First word stalled 10 cycles
        run_frame(10, words, nwords, pre_low, nfd, n_stall, stall_bad);
        check("stall_cycles", n_stall, 32'd10);
        check("stall_data_stable", stall_bad, 32'd0);
        check("stall_nwords", nwords, 32'd3);
        check("stall_words", {8'h00, words}, {8'h00, 24'hA503A6});

        // Counter wrap
        do_reset();
        pulse_count(256);
        check("wrap_count", {24'd0, count}, 32'h00);
        run_frame(0, words, nwords, pre_low, nfd, n_stall, stall_bad);
        check("wrap_words", {8'h00, words}, {8'h00, 24'hA500A5});
        check("wrap_frame_done", nfd, 32'd1);

        // Reset during the second WAIT, competing with other inputs
        do_reset();
        pulse_count(2);
        @(negedge clk_100); start_send = 1'b1;
        @(negedge clk_100); start_send = 1'b0;
        wait_valid(ok);
        check("rst_first_valid", {31'd0, ok}, 32'd1);
        bus.tx_ready_i = 1'b1;
        @(negedge clk_100); bus.tx_ready_i = 1'b0; bus.word_done_i = 1'b1;
        @(negedge clk_100); bus.word_done_i = 1'b0;
        check("rst_second_word", {bus.tx_valid_o, bus.tx_data_o}, {1'b1, 8'h02});
        bus.tx_ready_i = 1'b1;
        @(negedge clk_100); bus.tx_ready_i = 1'b0;
        check("rst_in_wait", {bus.tx_valid_o, busy}, {1'b0, 1'b1});
        s_rst = 1'b1; start_send = 1'b1; next_count = 1'b1; bus.word_done_i = 1'b1;
        @(negedge clk_100);
        s_rst = 1'b0; start_send = 1'b0; next_count = 1'b0; bus.word_done_i = 1'b0;
        check("rst_abort", {bus.tx_valid_o, bus.tx_data_o, bus.cs_n_o, busy, frame_done, dropped, count},
              {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        fd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100);
            if (frame_done || busy) fd_seen++;
        end
        check("rst_no_frame_done", fd_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
